// File: rtl/top.sv
// Three-register Geffe keystream generator.
// Each 8-bit Fibonacci LFSR shifts left one step per clock. The new bit enters at
// bit 0 and is the parity of the tapped bits. Reset reloads the seeds from the keys.
// The output bit takes s2[7] or s3[7], chosen by s1[7], and is combinational
// from the current registers.
module top #(
   parameter logic [7:0] TAPS1 = 8'b10111000,
   parameter logic [7:0] TAPS2 = 8'b10001110,
   parameter logic [7:0] TAPS3 = 8'b10010110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key1,
   input  logic [7:0] key2,
   input  logic [7:0] key3,
   output logic       keystream,
   output logic [7:0] LFSR_1_state,
   output logic [7:0] LFSR_2_state,
   output logic [7:0] LFSR_3_state
);

   // Per-register constants and inputs, gathered so one generate loop covers all three.
   logic [2:0][7:0] taps_all;
   logic [2:0][7:0] key_all;
   logic [2:0][7:0] state_all;

   assign taps_all = {TAPS3, TAPS2, TAPS1};
   assign key_all  = {key3, key2, key1};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lfsr
         logic [7:0] lfsr_q;
         logic [7:0] lfsr_d;
         logic [7:0] seed;

         // An all-zero seed would lock the register, so it is replaced by 0x01.
         assign seed = (key_all[gi] == 8'h00) ? 8'h01 : key_all[gi];

         // Next state: shift left, and feed in the parity of the tapped bits at bit 0.
         always_comb begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & taps_all[gi])};
         end

         // Register update: reset overrides shifting and loads the seed.
         always_ff @(posedge clk) begin
            if (rst) begin
               lfsr_q <= seed;
            end else begin
               lfsr_q <= lfsr_d;
            end
         end

         assign state_all[gi] = lfsr_q;
      end
   endgenerate

   assign LFSR_1_state = state_all[0];
   assign LFSR_2_state = state_all[1];
   assign LFSR_3_state = state_all[2];

   // Geffe combiner: the MSB of register 1 chooses between the MSBs of registers 2 and 3.
   assign keystream = (state_all[0][7] & state_all[1][7]) |
                      (~state_all[0][7] & state_all[2][7]);

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the Geffe keystream generator.
// The reference model steps each register from its polynomial with $countones parity.
// Directed cases cover the documented vectors. They are followed by a randomized
// run with random resets and key changes.
module tb_top;

   localparam logic [7:0] T1 = 8'b10111000;
   localparam logic [7:0] T2 = 8'b10001110;
   localparam logic [7:0] T3 = 8'b10010110;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key1, key2, key3;
   logic       keystream;
   logic [7:0] s1, s2, s3;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state of the three registers.
   logic [7:0] m1, m2, m3;

   always #5 clk = ~clk;

   top dut (
      .clk          (clk),
      .rst          (rst),
      .key1         (key1),
      .key2         (key2),
      .key3         (key3),
      .keystream    (keystream),
      .LFSR_1_state (s1),
      .LFSR_2_state (s2),
      .LFSR_3_state (s3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] poly_step(input logic [7:0] s, input logic [7:0] t);
      int c;
      c = $countones(s & t);
      return {s[6:0], c[0]};
   endfunction

   function automatic logic [7:0] seed_of(input logic [7:0] k);
      return (k == 8'h00) ? 8'h01 : k;
   endfunction

   function automatic logic geffe(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      return a[7] ? b[7] : c[7];
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) begin
         m1 = seed_of(key1);
         m2 = seed_of(key2);
         m3 = seed_of(key3);
      end else begin
         m1 = poly_step(m1, T1);
         m2 = poly_step(m2, T2);
         m3 = poly_step(m3, T3);
      end
      #1;
      check({tag, ".s1"}, {24'd0, s1}, {24'd0, m1});
      check({tag, ".s2"}, {24'd0, s2}, {24'd0, m2});
      check({tag, ".s3"}, {24'd0, s3}, {24'd0, m3});
      check({tag, ".ks"}, {31'd0, keystream}, {31'd0, geffe(m1, m2, m3)});
      $display("[TB] %s rst=%0b s=%h/%h/%h ks=%0b", tag, rst, s1, s2, s3, keystream);
   endtask

   logic [7:0] ref1 [10];
   logic [7:0] ref2 [10];
   logic [7:0] ref3 [10];
   logic [7:0] cipher, plain, exp_cipher;
   logic [7:0] e1, e2, e3;
   bit         zero_seen;

   initial begin
      rst  = 1'b1;
      key1 = 8'hC3;
      key2 = 8'hB9;
      key3 = 8'hE6;

      // Documented reset vector and first shift.
      tick("rst_vec");
      check("rst_vec.s1c", {24'd0, s1}, 32'hC3);
      check("rst_vec.s2c", {24'd0, s2}, 32'hB9);
      check("rst_vec.s3c", {24'd0, s3}, 32'hE6);
      check("rst_vec.ksc", {31'd0, keystream}, 32'd1);
      rst = 1'b0;
      tick("step1");
      check("step1.s1c", {24'd0, s1}, 32'h87);
      check("step1.s2c", {24'd0, s2}, 32'h72);
      check("step1.s3c", {24'd0, s3}, 32'hCD);
      check("step1.ksc", {31'd0, keystream}, 32'd0);

      // Record a reference run, then reset after 5 shifts and confirm it repeats.
      rst = 1'b1;
      tick("rerun_rst");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick("ref_run");
         ref1[i] = s1; ref2[i] = s2; ref3[i] = s3;
      end
      rst = 1'b1;
      tick("pre5_rst");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick("five");
      rst = 1'b1;
      tick("mid_rst");
      check("mid_rst.s1c", {24'd0, s1}, 32'hC3);
      check("mid_rst.s2c", {24'd0, s2}, 32'hB9);
      check("mid_rst.s3c", {24'd0, s3}, 32'hE6);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick("repeat");
         check("repeat.s1r", {24'd0, s1}, {24'd0, ref1[i]});
         check("repeat.s2r", {24'd0, s2}, {24'd0, ref2[i]});
         check("repeat.s3r", {24'd0, s3}, {24'd0, ref3[i]});
      end

      // Key changes while running are ignored until the next reset.
      key2 = 8'h55;
      for (int i = 0; i < 6; i++) tick("key_ignored");
      rst = 1'b1;
      tick("key2_rst");
      check("key2_rst.s2c", {24'd0, s2}, 32'h55);

      // Encrypt 0xAB LSB first, then decrypt after a re-reset with the same keys.
      key1 = 8'hC3; key2 = 8'hB9; key3 = 8'hE6;
      e1 = 8'hC3; e2 = 8'hB9; e3 = 8'hE6;
      exp_cipher = 8'h00;
      for (int i = 0; i < 8; i++) begin
         e1 = poly_step(e1, T1); e2 = poly_step(e2, T2); e3 = poly_step(e3, T3);
         exp_cipher[i] = 1'b1 ^ geffe(e1, e2, e3) ^ (((8'hAB >> i) & 8'h01) == 8'h00 ? 1'b1 : 1'b0);
      end
      tick("enc_rst");
      rst = 1'b0;
      cipher = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick("enc");
         cipher[i] = keystream ^ (((8'hAB >> i) & 8'h01) != 8'h00);
      end
      check("cipher", {24'd0, cipher}, {24'd0, exp_cipher});
      rst = 1'b1;
      tick("dec_rst");
      rst = 1'b0;
      plain = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick("dec");
         plain[i] = keystream ^ cipher[i];
      end
      check("decrypt", {24'd0, plain}, 32'hAB);

      // Zero key loads 0x01; the register cycles back after 255 steps without hitting zero.
      key1 = 8'h00;
      rst  = 1'b1;
      tick("zero_key");
      check("zero_key.s1c", {24'd0, s1}, 32'h01);
      rst = 1'b0;
      zero_seen = 1'b0;
      for (int i = 0; i < 255; i++) begin
         @(posedge clk);
         m1 = poly_step(m1, T1); m2 = poly_step(m2, T2); m3 = poly_step(m3, T3);
         #1;
         if (s1 == 8'h00) zero_seen = 1'b1;
         if (i == 253) check("period.early", {31'd0, (s1 == 8'h01)}, 32'd0);
      end
      check("period.s1", {24'd0, s1}, 32'h01);
      check("period.nozero", {31'd0, zero_seen}, 32'd0);
      check("period.s2", {24'd0, s2}, {24'd0, m2});
      check("period.s3", {24'd0, s3}, {24'd0, m3});

      // Randomized run: random keys (some zero) changing every cycle, random resets.
      for (int i = 0; i < 300; i++) begin
         rst  = ($urandom_range(0, 15) == 0);
         key1 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         key2 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         key3 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
